// File: rtl/perf_monitor.sv
// perf_monitor: per-class retire counters plus a RUN cycle counter, stopping
// on a cycle budget or on a jump-to-self loop, with a 1-cycle read port.
module perf_monitor #(
   parameter int CNT_W       = 32,
   parameter int CYCLE_LIMIT = 70,
   parameter int LOOP_LIMIT  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             ret_valid,
   input  logic [31:0]      ret_pc,
   input  logic [31:0]      ret_instr,
   input  logic             rd_req,
   input  logic [3:0]       rd_addr,
   output logic [CNT_W-1:0] rd_data,
   output logic             rd_valid,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             done,
   output logic [1:0]       done_cause,
   output logic             overflow
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   // Slots 0-14 are instruction classes, slot 15 is the cycle counter, so the
   // read address indexes the array directly.
   localparam int CYC_IDX = 15;

   state_t                 state, state_nxt;
   logic [15:0][CNT_W-1:0] cnt;
   logic [15:0]            inc, at_max;
   logic [3:0]             cls;
   logic [5:0]             opcode, funct;
   logic [31:0]            prev_pc, loop_cnt, loop_nxt;
   logic                   prev_vld, same_pc, retire, cyc_hit, loop_hit;
   logic                   unused_bits;

   assign opcode      = ret_instr[31:26];
   assign funct       = ret_instr[5:0];
   assign unused_bits = ^ret_instr[25:6];

   // Decode the retiring instruction into its class index
   always_comb begin
      cls = 4'd14;
      if (opcode == 6'd0) begin
         case (funct)
            6'd32:   cls = 4'd0;
            6'd34:   cls = 4'd1;
            6'd36:   cls = 4'd2;
            6'd37:   cls = 4'd3;
            6'd25:   cls = 4'd4;
            6'd18:   cls = 4'd5;
            6'd16:   cls = 4'd6;
            6'd0:    cls = 4'd7;
            default: cls = 4'd14;
         endcase
      end else begin
         case (opcode)
            6'd35:   cls = 4'd8;
            6'd43:   cls = 4'd9;
            6'd4:    cls = 4'd10;
            6'd2:    cls = 4'd11;
            6'd3:    cls = 4'd12;
            6'd9:    cls = 4'd13;
            default: cls = 4'd14;
         endcase
      end
   end

   // A retire is accepted in IDLE (it starts the run) and RUN, never in DONE.
   // The loop counter only means something once a previous PC exists.
   assign retire    = ret_valid && (state != ST_DONE);
   assign same_pc   = prev_vld && (ret_pc == prev_pc);
   assign loop_nxt  = same_pc ? loop_cnt + 32'd1 : 32'd0;
   // Compare at 64 bits so a narrow counter never aliases the limit.
   assign cyc_hit   = (state == ST_RUN) && (64'(cycle_cnt) == 64'(CYCLE_LIMIT - 1));
   assign loop_hit  = (state == ST_RUN) && ret_valid && (loop_nxt == 32'(LOOP_LIMIT - 1));
   assign cycle_cnt = cnt[CYC_IDX];
   assign done      = (state == ST_DONE);

   // Per-counter increment requests and saturation detect
   always_comb begin
      inc    = '0;
      at_max = '0;
      for (int i = 0; i < 15; i++) inc[i] = retire && (cls == 4'(i));
      inc[CYC_IDX] = (state == ST_RUN);
      for (int i = 0; i < 16; i++) at_max[i] = &cnt[i];
   end

   // Next-state logic; clr always returns to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (ret_valid) state_nxt = ST_RUN;
         ST_RUN:  if (cyc_hit || loop_hit) state_nxt = ST_DONE;
         default: state_nxt = state;
      endcase
      if (clr) state_nxt = ST_IDLE;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Counters, flags, loop tracking and read port; clr restores the reset state
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         cnt        <= '0;
         overflow   <= 1'b0;
         done_cause <= 2'b00;
         prev_pc    <= '0;
         prev_vld   <= 1'b0;
         loop_cnt   <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
      end else begin
         for (int i = 0; i < 16; i++)
            if (inc[i] && !at_max[i]) cnt[i] <= cnt[i] + CNT_W'(1);
         if (|(inc & at_max)) overflow <= 1'b1;
         // Cycle limit wins when both stop conditions land together
         if (state == ST_RUN && state_nxt == ST_DONE)
            done_cause <= cyc_hit ? 2'b01 : 2'b10;
         if (retire) begin
            prev_pc  <= ret_pc;
            prev_vld <= 1'b1;
            loop_cnt <= loop_nxt;
         end
         rd_valid <= rd_req;
         if (rd_req) rd_data <= cnt[rd_addr];
      end
   end

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: directed and random checks of perf_monitor against a
// cycle-level behavioural model; a CNT_W=4 copy exercises saturation.
module tb_perf_monitor;
   localparam int CLIM = 70;
   localparam int LLIM = 4;

   logic        clk = 1'b0, rst = 1'b0, clr = 1'b0, ret_valid = 1'b0, rd_req = 1'b0;
   logic [31:0] ret_pc = '0, ret_instr = '0;
   logic [3:0]  rd_addr = '0;

   logic [31:0] rd_data0, cyc0;
   logic        rd_valid0, done0, ovf0;
   logic [1:0]  cause0;
   logic [3:0]  rd_data1, cyc1;
   logic        rd_valid1, done1, ovf1;
   logic [1:0]  cause1;

   int errors = 0, checks = 0;
   int cur_cls = 0;

   // Model state, index 0 = 32-bit instance, 1 = 4-bit instance
   logic [63:0] m_cnt [2][16];
   logic [63:0] m_max [2];
   logic [63:0] m_rdd [2];
   logic [31:0] m_prev [2];
   int          m_st [2];     // 0 idle, 1 run, 2 done
   int          m_loop [2];
   int          m_cause [2];
   bit          m_pv [2], m_ovf [2], m_rdv [2];

   perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(CLIM), .LOOP_LIMIT(LLIM)) u0 (
      .clk(clk), .rst(rst), .clr(clr), .ret_valid(ret_valid), .ret_pc(ret_pc),
      .ret_instr(ret_instr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data0),
      .rd_valid(rd_valid0), .cycle_cnt(cyc0), .done(done0), .done_cause(cause0),
      .overflow(ovf0));

   perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(CLIM), .LOOP_LIMIT(LLIM)) u1 (
      .clk(clk), .rst(rst), .clr(clr), .ret_valid(ret_valid), .ret_pc(ret_pc),
      .ret_instr(ret_instr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .cycle_cnt(cyc1), .done(done1), .done_cause(cause1),
      .overflow(ovf1));

   always #5 clk = ~clk;

   function automatic void model_clear(int k);
      for (int i = 0; i < 16; i++) m_cnt[k][i] = '0;
      m_rdd[k] = '0; m_prev[k] = '0; m_st[k] = 0; m_loop[k] = 0;
      m_cause[k] = 0; m_pv[k] = 0; m_ovf[k] = 0; m_rdv[k] = 0;
   endfunction

   function automatic void bump(int k, int i);
      if (m_cnt[k][i] == m_max[k]) m_ovf[k] = 1;
      else m_cnt[k][i] = m_cnt[k][i] + 64'd1;
   endfunction

   // One clock of the monitor as described behaviourally
   function automatic void model_step(int k);
      bit run, cstop, lstop;
      if (!rst || clr) begin model_clear(k); return; end
      m_rdv[k] = rd_req;
      if (rd_req) m_rdd[k] = m_cnt[k][rd_addr];
      if (m_st[k] == 2) return;
      run = (m_st[k] == 1);
      if (!run && !ret_valid) return;
      cstop = 0; lstop = 0;
      if (run) begin
         cstop = (m_cnt[k][15] == 64'(CLIM - 1));
         bump(k, 15);
      end
      if (ret_valid) begin
         bump(k, cur_cls);
         if (m_pv[k] && ret_pc == m_prev[k]) m_loop[k]++; else m_loop[k] = 0;
         m_prev[k] = ret_pc; m_pv[k] = 1;
         lstop = run && (m_loop[k] == LLIM - 1);
      end
      if (cstop)      begin m_st[k] = 2; m_cause[k] = 1; end
      else if (lstop) begin m_st[k] = 2; m_cause[k] = 2; end
      else m_st[k] = 1;
   endfunction

   // Build an instruction word of the requested class with random filler bits
   function automatic logic [31:0] make_instr(int cls);
      logic [31:0] w;
      int fn [8]  = '{32, 34, 36, 37, 25, 18, 16, 0};
      int op [6]  = '{35, 43, 4, 2, 3, 9};
      int ofn [4] = '{1, 33, 42, 8};
      int oop [4] = '{15, 13, 63, 5};
      w = $urandom;
      if (cls < 8) begin w[31:26] = 6'd0; w[5:0] = 6'(fn[cls]); end
      else if (cls < 14) w[31:26] = 6'(op[cls-8]);
      else if ($urandom_range(1) == 0) begin w[31:26] = 6'd0; w[5:0] = 6'(ofn[$urandom_range(3)]); end
      else w[31:26] = 6'(oop[$urandom_range(3)]);
      return w;
   endfunction

   task automatic tick();
      model_step(0); model_step(1);
      @(posedge clk); #1;
   endtask

   task automatic ret(int cls, logic [31:0] pc);
      ret_valid = 1'b1; cur_cls = cls; ret_instr = make_instr(cls); ret_pc = pc;
      tick();
      ret_valid = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; tick(); rst = 1'b1;
      checks++; if (rd_data0 !== 32'd0) begin errors++; $display("FAIL rst_rd_data: got %0h want 0", rd_data0); end
      checks++; if (rd_valid0 !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %0b want 0", rd_valid0); end
      checks++; if (cyc0 !== 32'd0) begin errors++; $display("FAIL rst_cycle_cnt: got %0d want 0", cyc0); end
      checks++; if (done0 !== 1'b0 || cause0 !== 2'b00) begin errors++; $display("FAIL rst_done: got %0b/%0b want 0/00", done0, cause0); end
      checks++; if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b/%0b want 0/0", ovf0, ovf1); end
      // IDLE does not count cycles
      tick(); tick();
      checks++; if (cyc0 !== 32'd0) begin errors++; $display("FAIL idle_cycle_cnt: got %0d want 0", cyc0); end
   endtask

   task automatic test_basic();
      int addrs [6] = '{0, 8, 9, 10, 13, 14};
      logic [31:0] exp, last;
      ret(0, 32'h100); ret(8, 32'h104); ret(9, 32'h108); ret(10, 32'h10C); ret(13, 32'h110);
      foreach (addrs[j]) begin
         rd_req = 1'b1; rd_addr = 4'(addrs[j]);
         tick(); rd_req = 1'b0;
         exp = (addrs[j] == 14) ? 32'd0 : 32'd1;
         checks++; if (rd_valid0 !== 1'b1 || rd_data0 !== exp) begin errors++;
            $display("FAIL basic_rd[%0d]: got v=%0b d=%0d want v=1 d=%0d", addrs[j], rd_valid0, rd_data0, exp); end
      end
      rd_req = 1'b1; rd_addr = 4'd15; tick(); rd_req = 1'b0;
      checks++; if (rd_data0 !== m_rdd[0][31:0]) begin errors++; $display("FAIL basic_rd_cyc: got %0d want %0d", rd_data0, m_rdd[0][31:0]); end
      last = m_rdd[0][31:0];
      tick();
      checks++; if (rd_valid0 !== 1'b0 || rd_data0 !== last) begin errors++;
         $display("FAIL basic_rd_hold: got v=%0b d=%0d want v=0 d=%0d", rd_valid0, rd_data0, last); end
   endtask

   task automatic test_cycle_limit();
      logic [63:0] sum;
      do_clr();
      for (int i = 0; i < 80; i++) begin
         ret($urandom_range(14), 32'h1000 + 32'(4 * i));
         if (i == 69) begin
            checks++; if (done0 !== 1'b0 || cyc0 !== 32'd69) begin errors++; $display("FAIL lim_before: got done=%0b cyc=%0d want 0/69", done0, cyc0); end
         end
         if (i == 70) begin
            checks++; if (done0 !== 1'b1 || cause0 !== 2'b01 || cyc0 !== 32'd70) begin errors++;
               $display("FAIL lim_done: got done=%0b cause=%0b cyc=%0d want 1/01/70", done0, cause0, cyc0); end
         end
      end
      sum = '0;
      for (int a = 0; a < 15; a++) begin
         rd_req = 1'b1; rd_addr = 4'(a); tick(); rd_req = 1'b0;
         checks++; if (rd_data0 !== m_rdd[0][31:0]) begin errors++; $display("FAIL lim_cls[%0d]: got %0d want %0d", a, rd_data0, m_rdd[0][31:0]); end
         sum = sum + 64'(rd_data0);
      end
      checks++; if (sum !== 64'd71 || cyc0 !== 32'd70 || done0 !== 1'b1) begin errors++;
         $display("FAIL lim_frozen: got sum=%0d cyc=%0d done=%0b want 71/70/1", sum, cyc0, done0); end
   endtask

   task automatic test_both_stop();
      do_clr();
      for (int i = 0; i <= 70; i++) ret($urandom_range(14), (i >= 67) ? 32'h2000 : 32'h1000 + 32'(4 * i));
      checks++; if (done0 !== 1'b1 || cause0 !== 2'b01) begin errors++; $display("FAIL both_stop: got done=%0b cause=%0b want 1/01", done0, cause0); end
   endtask

   task automatic test_loop();
      do_clr();
      ret(11, 32'h20); ret(11, 32'h20); ret(11, 32'h20); ret(0, 32'h30);
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL loop_3rep: got done=%0b want 0", done0); end
      ret(11, 32'h40); ret(11, 32'h40); ret(11, 32'h40);
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL loop_3rd: got done=%0b want 0", done0); end
      ret(11, 32'h40);
      checks++; if (done0 !== 1'b1 || cause0 !== 2'b10) begin errors++; $display("FAIL loop_4th: got done=%0b cause=%0b want 1/10", done0, cause0); end
      rd_req = 1'b1; rd_addr = 4'd11; tick(); rd_req = 1'b0;
      checks++; if (rd_data0 !== 32'd7) begin errors++; $display("FAIL loop_j_cnt: got %0d want 7", rd_data0); end
   endtask

   task automatic test_overflow();
      do_clr();
      for (int i = 0; i < 17; i++) ret(0, 32'h3000 + 32'(4 * i));
      rd_req = 1'b1; rd_addr = 4'd0; tick(); rd_req = 1'b0;
      checks++; if (rd_data1 !== 4'd15 || ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_sat: got d=%0d ovf=%0b want 15/1", rd_data1, ovf1); end
      checks++; if (rd_data0 !== 32'd17 || ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_wide: got d=%0d ovf=%0b want 17/0", rd_data0, ovf0); end
      repeat (5) tick();
      checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", ovf1); end
      do_clr();
      checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b want 0", ovf1); end
   endtask

   task automatic test_clr_read();
      do_clr();
      repeat (4) ret(2, 32'h50);
      checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL clrrd_pre: got done=%0b want 1", done0); end
      clr = 1'b1; rd_req = 1'b1; rd_addr = 4'd2; tick(); clr = 1'b0; rd_req = 1'b0;
      checks++; if (rd_valid0 !== 1'b0 || done0 !== 1'b0 || cause0 !== 2'b00 || cyc0 !== 32'd0) begin errors++;
         $display("FAIL clrrd_out: got v=%0b done=%0b cause=%0b cyc=%0d want 0/0/00/0", rd_valid0, done0, cause0, cyc0); end
      tick();
      checks++; if (cyc0 !== 32'd0) begin errors++; $display("FAIL clrrd_idle: got cyc=%0d want 0", cyc0); end
      for (int a = 0; a < 16; a++) begin
         rd_req = 1'b1; rd_addr = 4'(a); tick(); rd_req = 1'b0;
         checks++; if (rd_data0 !== 32'd0 || rd_valid0 !== 1'b1) begin errors++; $display("FAIL clrrd_zero[%0d]: got d=%0d v=%0b want 0/1", a, rd_data0, rd_valid0); end
      end
   endtask

   task automatic test_rst_mid();
      do_clr();
      for (int i = 0; i < 5; i++) ret($urandom_range(14), 32'h4000 + 32'(4 * i));
      rst = 1'b0; rd_req = 1'b1; rd_addr = 4'd15; ret_valid = 1'b1; cur_cls = 0;
      ret_instr = make_instr(0); ret_pc = 32'h5000;
      tick();
      rst = 1'b1; rd_req = 1'b0; ret_valid = 1'b0;
      checks++; if (rd_valid0 !== 1'b0 || rd_data0 !== 32'd0 || cyc0 !== 32'd0) begin errors++;
         $display("FAIL rstmid_rd: got v=%0b d=%0d cyc=%0d want 0/0/0", rd_valid0, rd_data0, cyc0); end
      checks++; if (done0 !== 1'b0 || cause0 !== 2'b00 || ovf0 !== 1'b0) begin errors++;
         $display("FAIL rstmid_flags: got done=%0b cause=%0b ovf=%0b want 0/00/0", done0, cause0, ovf0); end
      tick();
      checks++; if (cyc0 !== 32'd0) begin errors++; $display("FAIL rstmid_idle: got cyc=%0d want 0", cyc0); end
   endtask

   task automatic test_random();
      logic [31:0] pcs [4];
      do_clr();
      for (int n = 0; n < 600; n++) begin
         pcs = '{32'h10, 32'h14, 32'h18, $urandom};
         ret_valid = ($urandom_range(3) != 0);
         cur_cls   = $urandom_range(14);
         ret_instr = make_instr(cur_cls);
         ret_pc    = pcs[$urandom_range(3)];
         rd_req    = $urandom_range(1);
         rd_addr   = 4'($urandom_range(15));
         clr       = ($urandom_range(39) == 0);
         tick();
         checks++; if (rd_valid0 !== m_rdv[0] || rd_data0 !== m_rdd[0][31:0]) begin errors++;
            $display("FAIL rnd_rd0 @%0d: got v=%0b d=%0h want v=%0b d=%0h", n, rd_valid0, rd_data0, m_rdv[0], m_rdd[0][31:0]); end
         checks++; if (cyc0 !== m_cnt[0][15][31:0] || done0 !== (m_st[0] == 2) || cause0 !== 2'(m_cause[0]) || ovf0 !== m_ovf[0]) begin errors++;
            $display("FAIL rnd_st0 @%0d: got cyc=%0d done=%0b cause=%0d ovf=%0b want %0d/%0b/%0d/%0b", n, cyc0, done0, cause0, ovf0,
                     m_cnt[0][15][31:0], m_st[0] == 2, m_cause[0], m_ovf[0]); end
         checks++; if (rd_valid1 !== m_rdv[1] || rd_data1 !== m_rdd[1][3:0] || cyc1 !== m_cnt[1][15][3:0] || done1 !== (m_st[1] == 2)
                       || cause1 !== 2'(m_cause[1]) || ovf1 !== m_ovf[1]) begin errors++;
            $display("FAIL rnd_n1 @%0d: got v=%0b d=%0d cyc=%0d done=%0b cause=%0d ovf=%0b want %0b/%0d/%0d/%0b/%0d/%0b", n, rd_valid1, rd_data1,
                     cyc1, done1, cause1, ovf1, m_rdv[1], m_rdd[1][3:0], m_cnt[1][15][3:0], m_st[1] == 2, m_cause[1], m_ovf[1]); end
      end
      clr = 1'b0; ret_valid = 1'b0; rd_req = 1'b0;
   endtask

   initial begin
      m_max[0] = 64'hFFFF_FFFF;
      m_max[1] = 64'd15;
      model_clear(0); model_clear(1);
      test_reset();
      test_basic();
      test_cycle_limit();
      test_both_stop();
      test_loop();
      test_overflow();
      test_clr_read();
      test_rst_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
